// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the ALU/LSU producers, decode reservations and the
// register file write port. The slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NREG = 32
);
  // ALU write-back request
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;

  // LSU write-back request
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;

  // Decode-time destination reservation
  logic            rsv_en;
  logic [AW-1:0]   rsv_rd;

  // Registered register file write port and scoreboard
  logic            wr_en;
  logic [AW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [NREG-1:0] busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  rsv_en, rsv_rd,
    output alu_ready, lsu_ready,
    output wr_en, wr_rd, wr_data, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output rsv_en, rsv_rd,
    input  alu_ready, lsu_ready,
    input  wr_en, wr_rd, wr_data, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register file write port between the ALU (requester 0)
// and the LSU (requester 1). Each producer owns a one-entry slot; a
// round-robin arbiter drains full slots into a registered write port, and a
// per-register busy scoreboard tracks reserved-but-uncommitted destinations.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NREG = 32
) (
  input logic                   clk,
  input logic                   reset,
  regfile_wb_arbiter_if.slave   bus
);

  typedef enum logic {
    GntAlu = 1'b0,
    GntLsu = 1'b1
  } grant_e;

  // Holding slots
  logic            alu_full_q, alu_full_d;
  logic [AW-1:0]   alu_rd_q, alu_rd_d;
  logic [XLEN-1:0] alu_data_q, alu_data_d;
  logic            lsu_full_q, lsu_full_d;
  logic [AW-1:0]   lsu_rd_q, lsu_rd_d;
  logic [XLEN-1:0] lsu_data_q, lsu_data_d;

  // Arbiter history
  grant_e          last_q, last_d;

  // Registered write port
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_rd_q, wr_rd_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  // Scoreboard
  logic [NREG-1:0] busy_q, busy_d;

  logic gnt_alu, gnt_lsu;
  logic alu_ready, lsu_ready;
  logic alu_fire, lsu_fire;

  // Round-robin grant over full slots; on a tie the last winner yields.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    if (alu_full_q && lsu_full_q) begin
      if (last_q == GntAlu) begin
        gnt_lsu = 1'b1;
      end else begin
        gnt_alu = 1'b1;
      end
    end else begin
      gnt_alu = alu_full_q;
      gnt_lsu = lsu_full_q;
    end
  end

  // Ready depends only on slot state and grant, so a slot being drained can
  // refill on the same edge; held low while reset is asserted.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!reset) begin
      alu_ready = !alu_full_q || gnt_alu;
      lsu_ready = !lsu_full_q || gnt_lsu;
    end
    alu_fire = bus.alu_valid && alu_ready;
    lsu_fire = bus.lsu_valid && lsu_ready;
  end

  // Slot next state: drain on grant, then refill from an accepted request.
  // Requests targeting x0 complete the handshake but are dropped here.
  always_comb begin
    alu_full_d = alu_full_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    lsu_full_d = lsu_full_q;
    lsu_rd_d   = lsu_rd_q;
    lsu_data_d = lsu_data_q;

    if (gnt_alu) begin
      alu_full_d = 1'b0;
    end
    if (alu_fire && (bus.alu_rd != '0)) begin
      alu_full_d = 1'b1;
      alu_rd_d   = bus.alu_rd;
      alu_data_d = bus.alu_data;
    end

    if (gnt_lsu) begin
      lsu_full_d = 1'b0;
    end
    if (lsu_fire && (bus.lsu_rd != '0)) begin
      lsu_full_d = 1'b1;
      lsu_rd_d   = bus.lsu_rd;
      lsu_data_d = bus.lsu_data;
    end
  end

  // Output stage: load the granted slot; index/data hold when idle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    if (gnt_alu) begin
      wr_en_d   = 1'b1;
      wr_rd_d   = alu_rd_q;
      wr_data_d = alu_data_q;
      last_d    = GntAlu;
    end else if (gnt_lsu) begin
      wr_en_d   = 1'b1;
      wr_rd_d   = lsu_rd_q;
      wr_data_d = lsu_data_q;
      last_d    = GntLsu;
    end
  end

  // Scoreboard: clear on the register file commit edge, a same-edge
  // reservation of the same register wins, x0 never becomes busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_rd_q] = 1'b0;
    end
    if (bus.rsv_en && (bus.rsv_rd != '0)) begin
      busy_d[bus.rsv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_full_q <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      lsu_full_q <= 1'b0;
      lsu_rd_q   <= '0;
      lsu_data_q <= '0;
      last_q     <= GntAlu;
      wr_en_q    <= 1'b0;
      wr_rd_q    <= '0;
      wr_data_q  <= '0;
      busy_q     <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      lsu_full_q <= lsu_full_d;
      lsu_rd_q   <= lsu_rd_d;
      lsu_data_q <= lsu_data_d;
      last_q     <= last_d;
      wr_en_q    <= wr_en_d;
      wr_rd_q    <= wr_rd_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.lsu_ready = lsu_ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_rd     = wr_rd_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;

  // Only one slot may be drained per cycle.
  grant_onehot_a: assert property (@(posedge clk) disable iff (reset) !(gnt_alu && gnt_lsu));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1 time unit after the
// rising edge, outputs are checked at the same point.
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  regfile_wb_arbiter_if #(.XLEN(32), .AW(5), .NREG(32)) bus ();

  regfile_wb_arbiter #(.XLEN(32), .AW(5), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
    bus.rsv_en    = 1'b0;
    bus.rsv_rd    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_vec++; if (bus.wr_en !== 1'b0) begin n_miss++; $display("FAIL reset_wr_en: got %0h want 0", bus.wr_en); end
    n_vec++; if (bus.wr_rd !== 5'd0) begin n_miss++; $display("FAIL reset_wr_rd: got %0h want 0", bus.wr_rd); end
    n_vec++; if (bus.wr_data !== 32'h0) begin n_miss++; $display("FAIL reset_wr_data: got %0h want 0", bus.wr_data); end
    n_vec++; if (bus.busy !== 32'h0) begin n_miss++; $display("FAIL reset_busy: got %0h want 0", bus.busy); end
    n_vec++; if (bus.alu_ready !== 1'b0) begin n_miss++; $display("FAIL reset_alu_ready: got %0h want 0", bus.alu_ready); end
    n_vec++; if (bus.lsu_ready !== 1'b0) begin n_miss++; $display("FAIL reset_lsu_ready: got %0h want 0", bus.lsu_ready); end
    step();
    reset = 1'b0;
    #1;
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_miss++; $display("FAIL release_alu_ready: got %0h want 1", bus.alu_ready); end
    n_vec++; if (bus.lsu_ready !== 1'b1) begin n_miss++; $display("FAIL release_lsu_ready: got %0h want 1", bus.lsu_ready); end
  endtask

  task automatic test_single();
    bus.rsv_en = 1'b1;
    bus.rsv_rd = 5'd5;
    step();
    bus.rsv_en = 1'b0;
    n_vec++; if (bus.busy !== 32'h20) begin n_miss++; $display("FAIL single_rsv: got %0h want 20", bus.busy); end
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_miss++; $display("FAIL single_ready: got %0h want 1", bus.alu_ready); end
    step();  // edge k: accepted
    bus.alu_valid = 1'b0;
    n_vec++; if (bus.wr_en !== 1'b0) begin n_miss++; $display("FAIL single_k_wr_en: got %0h want 0", bus.wr_en); end
    step();  // edge k+1: write visible
    n_vec++; if (bus.wr_en !== 1'b1) begin n_miss++; $display("FAIL single_wr_en: got %0h want 1", bus.wr_en); end
    n_vec++; if (bus.wr_rd !== 5'd5) begin n_miss++; $display("FAIL single_wr_rd: got %0d want 5", bus.wr_rd); end
    n_vec++; if (bus.wr_data !== 32'hDEADBEEF) begin n_miss++; $display("FAIL single_wr_data: got %0h want deadbeef", bus.wr_data); end
    n_vec++; if (bus.busy !== 32'h20) begin n_miss++; $display("FAIL single_busy_held: got %0h want 20", bus.busy); end
    step();  // edge k+2: commit
    n_vec++; if (bus.wr_en !== 1'b0) begin n_miss++; $display("FAIL single_one_cycle: got %0h want 0", bus.wr_en); end
    n_vec++; if (bus.wr_rd !== 5'd5) begin n_miss++; $display("FAIL single_rd_hold: got %0d want 5", bus.wr_rd); end
    n_vec++; if (bus.wr_data !== 32'hDEADBEEF) begin n_miss++; $display("FAIL single_data_hold: got %0h want deadbeef", bus.wr_data); end
    n_vec++; if (bus.busy !== 32'h0) begin n_miss++; $display("FAIL single_busy_clear: got %0h want 0", bus.busy); end
  endtask

  task automatic test_tie();
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h22;
    step();  // edge k: both accepted
    bus.lsu_valid = 1'b0;
    bus.alu_rd = 5'd6; bus.alu_data = 32'h33;
    n_vec++; if (bus.alu_ready !== 1'b0) begin n_miss++; $display("FAIL tie_alu_ready: got %0h want 0", bus.alu_ready); end
    n_vec++; if (bus.lsu_ready !== 1'b1) begin n_miss++; $display("FAIL tie_lsu_ready: got %0h want 1", bus.lsu_ready); end
    step();  // edge k+1: LSU wins
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd4 || bus.wr_data !== 32'h22) begin
      n_miss++; $display("FAIL tie_first: got en=%0h rd=%0d data=%0h want en=1 rd=4 data=22", bus.wr_en, bus.wr_rd, bus.wr_data);
    end
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_miss++; $display("FAIL tie_alu_ready2: got %0h want 1", bus.alu_ready); end
    step();  // edge k+2: ALU drains, second ALU request enters
    bus.alu_valid = 1'b0;
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd3 || bus.wr_data !== 32'h11) begin
      n_miss++; $display("FAIL tie_second: got en=%0h rd=%0d data=%0h want en=1 rd=3 data=11", bus.wr_en, bus.wr_rd, bus.wr_data);
    end
    step();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd6 || bus.wr_data !== 32'h33) begin
      n_miss++; $display("FAIL tie_third: got en=%0h rd=%0d data=%0h want en=1 rd=6 data=33", bus.wr_en, bus.wr_rd, bus.wr_data);
    end
    step();
    n_vec++; if (bus.wr_en !== 1'b0) begin n_miss++; $display("FAIL tie_drained: got %0h want 0", bus.wr_en); end
  endtask

  task automatic test_back_to_back();
    int exp_rd [9];
    int ai;
    int li;
    int n;
    logic af;
    logic lf;
    logic want_en;
    exp_rd = '{20, 10, 21, 11, 22, 12, 23, 13, 24};
    ai = 0;
    li = 0;
    n  = 0;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      bus.alu_valid = (e <= 8);
      bus.alu_rd    = 5'(10 + ai);
      bus.alu_data  = 32'hD000_0000 | 32'(10 + ai);
      bus.lsu_valid = (e <= 8);
      bus.lsu_rd    = 5'(20 + li);
      bus.lsu_data  = 32'hD000_0000 | 32'(20 + li);
      @(negedge clk);
      af = bus.alu_valid && bus.alu_ready;
      lf = bus.lsu_valid && bus.lsu_ready;
      step();
      if (af) ai++;
      if (lf) li++;
      want_en = (e >= 2) && (e <= 10);
      n_vec++; if (bus.wr_en !== want_en) begin
        n_miss++; $display("FAIL b2b_wr_en edge %0d: got %0h want %0h", e, bus.wr_en, want_en);
      end
      if (bus.wr_en === 1'b1) begin
        if (n < 9) begin
          n_vec++; if (bus.wr_rd !== 5'(exp_rd[n]) || bus.wr_data !== (32'hD000_0000 | 32'(exp_rd[n]))) begin
            n_miss++; $display("FAIL b2b_order #%0d: got rd=%0d data=%0h want rd=%0d", n, bus.wr_rd, bus.wr_data, exp_rd[n]);
          end
        end
        n++;
      end
    end
    idle_inputs();
    n_vec++; if (n != 9) begin n_miss++; $display("FAIL b2b_count: got %0d writes want 9", n); end
    n_vec++; if (ai != 4 || li != 5) begin n_miss++; $display("FAIL b2b_accepts: got alu=%0d lsu=%0d want alu=4 lsu=5", ai, li); end
  endtask

  task automatic test_x0();
    logic [31:0] b0;
    b0 = bus.busy;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h5;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_miss++; $display("FAIL x0_ready: got %0h want 1", bus.alu_ready); end
    step();  // edge k: both handshakes complete
    idle_inputs();
    n_vec++; if (bus.wr_en !== 1'b0) begin n_miss++; $display("FAIL x0_k_wr_en: got %0h want 0", bus.wr_en); end
    n_vec++; if (bus.alu_ready !== 1'b1) begin n_miss++; $display("FAIL x0_slot_empty: got %0h want 1", bus.alu_ready); end
    step();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd7 || bus.wr_data !== 32'h77) begin
      n_miss++; $display("FAIL x0_lsu_write: got en=%0h rd=%0d data=%0h want en=1 rd=7 data=77", bus.wr_en, bus.wr_rd, bus.wr_data);
    end
    step();
    n_vec++; if (bus.wr_en !== 1'b0) begin n_miss++; $display("FAIL x0_no_write: got %0h want 0", bus.wr_en); end
    n_vec++; if (bus.busy !== b0) begin n_miss++; $display("FAIL x0_busy: got %0h want %0h", bus.busy, b0); end
  endtask

  task automatic test_rsv_collide();
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd9;
    step();
    bus.rsv_en = 1'b0;
    n_vec++; if (bus.busy !== 32'h200) begin n_miss++; $display("FAIL rsv_set: got %0h want 200", bus.busy); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    step();  // edge k
    bus.alu_valid = 1'b0;
    step();  // edge k+1: wr_* shows rd 9
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd9;
    step();  // edge k+2: commit and reserve collide
    bus.rsv_en = 1'b0;
    n_vec++; if (bus.busy !== 32'h200) begin n_miss++; $display("FAIL rsv_wins: got %0h want 200", bus.busy); end
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd9;  // re-reserve while busy
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h9A;
    step();
    idle_inputs();
    n_vec++; if (bus.busy !== 32'h200) begin n_miss++; $display("FAIL rsv_rereserve: got %0h want 200", bus.busy); end
    step();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'h9A) begin
      n_miss++; $display("FAIL rsv_second_write: got en=%0h data=%0h want en=1 data=9a", bus.wr_en, bus.wr_data);
    end
    step();
    n_vec++; if (bus.busy !== 32'h0) begin n_miss++; $display("FAIL rsv_clear: got %0h want 0", bus.busy); end
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd0;
    step();
    bus.rsv_en = 1'b0;
    n_vec++; if (bus.busy !== 32'h0) begin n_miss++; $display("FAIL rsv_x0: got %0h want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int nw;
    bus.rsv_en = 1'b1; bus.rsv_rd = 5'd8;
    step();
    bus.rsv_rd = 5'd9;
    step();
    bus.rsv_en = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
    step();
    bus.alu_rd = 5'd8; bus.alu_data = 32'h88;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    step();  // ALU rd 2 written, both slots refilled
    idle_inputs();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.busy !== 32'h300) begin
      n_miss++; $display("FAIL mid_pre: got en=%0h busy=%0h want en=1 busy=300", bus.wr_en, bus.busy);
    end
    n_vec++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b1) begin
      n_miss++; $display("FAIL mid_pre_ready: got alu=%0h lsu=%0h want alu=0 lsu=1", bus.alu_ready, bus.lsu_ready);
    end
    reset = 1'b1;
    #1;
    n_vec++; if (bus.wr_en !== 1'b0 || bus.busy !== 32'h0 || bus.wr_rd !== 5'd0) begin
      n_miss++; $display("FAIL mid_async: got en=%0h busy=%0h rd=%0d want 0 0 0", bus.wr_en, bus.busy, bus.wr_rd);
    end
    n_vec++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
      n_miss++; $display("FAIL mid_ready: got alu=%0h lsu=%0h want 0 0", bus.alu_ready, bus.lsu_ready);
    end
    step();
    reset = 1'b0;
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.wr_en === 1'b1) nw++;
    end
    n_vec++; if (nw != 0) begin n_miss++; $display("FAIL mid_residual: got %0d writes want 0", nw); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd13; bus.lsu_data = 32'hD;
    step();
    idle_inputs();
    step();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd13) begin
      n_miss++; $display("FAIL mid_tie_lsu: got en=%0h rd=%0d want en=1 rd=13", bus.wr_en, bus.wr_rd);
    end
    step();
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_rd !== 5'd12) begin
      n_miss++; $display("FAIL mid_tie_alu: got en=%0h rd=%0d want en=1 rd=12", bus.wr_en, bus.wr_rd);
    end
    step();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_x0();
    test_rsv_collide();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back producers: requester 0 is the ALU, requester 1 is the load/store unit (LSU).
- Each producer gets a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter drains the slots into a registered write port that drives the register file's wr_en/rd/wr_data.
- It also keeps a per-register busy scoreboard so decode can stall on pending writes.

Parameters:
XLEN, 32, data width of write-back values
AW, 5, register index width
NREG, 32, number of architectural registers (2**AW)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU write-back request
alu_ready  output  1  ALU slot can accept this cycle
alu_rd  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  LSU write-back request
lsu_ready  output  1  LSU slot can accept this cycle
lsu_rd  input  AW  LSU destination register
lsu_data  input  XLEN  load data
rsv_en  input  1  decode reserves a destination register at issue
rsv_rd  input  AW  register being reserved
wr_en  output  1  register file write enable (registered)
wr_rd  output  AW  register file write index (registered)
wr_data  output  XLEN  register file write data (registered)
busy  output  NREG  scoreboard; bit i = write to register i pending

Behaviour:
- Reset (asynchronous):
  - Slots empty; wr_en=0, wr_rd=0, wr_data=0, busy=0.
  - last_grant=ALU, so the LSU wins the first tie.
  - alu_ready=lsu_ready=0 while reset is high.
  - Reset mid-operation discards slot contents and pending busy bits with no write issued.
- Handshake: transfer on the rising edge when X_valid && X_ready.
  - X_ready = !slot_full || slot_granted_this_cycle, which gives back-to-back acceptance at one per cycle.
  - X_ready is combinational from slot state and grant, never from X_valid.
- x0 filtering: an accepted request with rd==0 completes the handshake but does not fill the slot, is never written, and leaves busy unchanged.
- Arbitration (combinational, each cycle, over full slots):
  - Exactly one slot full: grant it.
  - Both full: grant the requester not equal to last_grant.
  - last_grant updates on every grant.
- Output stage, on the grant edge:
  - wr_en<=1, wr_rd<=slot.rd, wr_data<=slot.data.
  - The slot empties on the same edge, and may refill on that edge from a new handshake.
  - With no grant: wr_en<=0, and wr_rd/wr_data hold their values.
- Latency:
  - Request accepted at edge k appears on wr_* after edge k+1 when uncontended.
  - A request that loses arbitration appears after edge k+2; this is the worst case.
  - The register file commits at the edge after wr_* becomes visible.
- Scoreboard:
  - busy[r] sets on the edge with rsv_en && rsv_r==r, for r!=0.
  - busy[r] clears on the edge where wr_en==1 && wr_rd==r, i.e. the register file commit edge.
  - Set and clear on the same edge for the same r: set wins (new producer).
  - busy[0] is constant 0. Re-reserving an already busy register keeps it at 1.
- Ordering: writes to the same rd from both slots commit in grant order. Decode uses busy to avoid WAW. The block does no extra hazard checking.
- Throughput: at most one register file write per cycle. Sustained dual-source traffic alternates ALU/LSU, and each source sees ready low on alternate cycles.

Test Plan:
- Reset release, single ALU write alu_rd=5, alu_data=0xDEADBEEF at edge k -> wr_en=1, wr_rd=5, wr_data=0xDEADBEEF after edge k+1, for exactly one cycle; busy[5] (reserved earlier) clears at edge k+2.
- Simultaneous first requests ALU rd=3/0x11 and LSU rd=4/0x22 at edge k -> LSU writes after k+1 and ALU after k+2. alu_ready=0 in cycle k+1 if ALU presents a second request.
- Both sources valid continuously for 8 cycles with distinct rd -> wr_en high every cycle, strict ALU/LSU alternation, no lost or duplicated writes (scoreboard check against expected queue).
- alu_rd=0 with valid=1, alu_data=0x5 -> handshake completes, wr_en stays 0, busy unchanged; a concurrent lsu_rd=7 write proceeds with uncontended latency.
- rsv_en rd=9 on the same edge as the commit of wr_rd=9 -> busy[9] remains 1. A later commit to 9 clears it. rsv_rd=0 never sets busy[0].
- Assert reset while both slots are full and busy=0x0000_0300 -> wr_en, busy, and ready drop immediately. After release there are no residual writes, and the first tie is won by the LSU.
